// File: rtl/gcd_defs_pkg.sv
// Shared definitions for the subtraction-based GCD controller: state encodings
// and the default operand width. Optional iteration counter: GCD_ITER_COUNT_EN.
package gcd_defs;
    localparam int GCD_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, magnitude compare and the two subtractors used by the
// GCD controller; the controller decides when to load and when to step.
module gcd_datapath
    import gcd_defs::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt
);
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;

    assign eq        = (a == b);
    assign gt        = (a > b);
    assign a_minus_b = a - b;
    assign b_minus_a = b - a;

    // Only the larger operand is reduced, so neither subtraction can wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= a_in;
            b <= b_in;
        end else if (step) begin
            if (gt) begin
                a <= a_minus_b;
            end else begin
                b <= b_minus_a;
            end
        end
    end
endmodule

// File: rtl/gcd_ctrl.sv
// Sequencing FSM for the subtraction GCD: IDLE -> CALC -> DONE -> IDLE.
// Define GCD_ITER_COUNT_EN to add the saturating iter_cnt subtraction counter.
module gcd_ctrl
    import gcd_defs::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef GCD_ITER_COUNT_EN
    output logic [WIDTH-1:0] iter_cnt,
`endif
    output logic [1:0]       state_dbg
);
    // Handshake: start is a request taken only while busy=0 (IDLE); it is
    // dropped, not queued, otherwise. done is a single-cycle completion pulse
    // and result stays valid from done until the next accepted start.
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             load;
    logic             step;
    logic             zero_op;
    logic             eq;
    logic             gt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    assign load    = (state == ST_IDLE) && start;
    assign step    = (state == ST_CALC) && !eq;
    assign zero_op = (a_in == '0) || (b_in == '0);

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a_in (a_in),
        .b_in (b_in),
        .a    (a),
        .b    (b),
        .eq   (eq),
        .gt   (gt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = zero_op ? ST_DONE : ST_CALC;
            ST_CALC: if (eq)    state_nxt = ST_DONE;
            ST_DONE:            state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero operand short-circuits: gcd(x,0)=x and gcd(0,0)=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (load && zero_op) begin
            result <= a_in | b_in;
        end else if ((state == ST_CALC) && eq) begin
            result <= a;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (load) begin
            iter_cnt <= '0;
        end else if (step && (iter_cnt != '1)) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`endif

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;
endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl: a vector table of operand pairs with
// hand-computed GCD, subtraction count and latency, plus multi-cycle sequences.
module tb_gcd_ctrl;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [3:0] iter_cnt;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    gcd_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
`ifdef GCD_ITER_COUNT_EN
        .iter_cnt (iter_cnt),
`endif
        .state_dbg(state_dbg)
    );

`ifndef GCD_ITER_COUNT_EN
    assign iter_cnt = '0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        int         iters;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_iters(input string name, input int exp);
`ifdef GCD_ITER_COUNT_EN
        check(name, int'(iter_cnt), exp);
`endif
    endtask

    // Latency counts clock edges from the accepting edge (1) to the edge after
    // which done is high; -1 means done never arrived within the budget.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                a_in  = 4'($urandom_range(15));
                b_in  = 4'($urandom_range(15));
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{4'd12, 4'd8,  4'd4,  2,  4};
        vecs[1]  = '{4'd15, 4'd1,  4'd1,  14, 16};
        vecs[2]  = '{4'd0,  4'd9,  4'd9,  0,  1};
        vecs[3]  = '{4'd0,  4'd0,  4'd0,  0,  1};
        vecs[4]  = '{4'd7,  4'd7,  4'd7,  0,  2};
        vecs[5]  = '{4'd6,  4'd9,  4'd3,  2,  4};
        vecs[6]  = '{4'd9,  4'd0,  4'd9,  0,  1};
        vecs[7]  = '{4'd15, 4'd15, 4'd15, 0,  2};
        vecs[8]  = '{4'd1,  4'd15, 4'd1,  14, 16};
        vecs[9]  = '{4'd10, 4'd4,  4'd2,  3,  5};
        vecs[10] = '{4'd13, 4'd5,  4'd1,  5,  7};
        vecs[11] = '{4'd14, 4'd6,  4'd2,  4,  6};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   int'(busy),      0);
        check("reset_done",   int'(done),      0);
        check("reset_result", int'(result),    0);
        check("reset_state",  int'(state_dbg), 0);
        check_iters("reset_iter", 0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven vectors
        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, lat);
            check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            check($sformatf("v%0d_result", k), int'(result), int'(vecs[k].res));
            check_iters($sformatf("v%0d_iters", k), vecs[k].iters);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_drop", k), int'(done), 0);
            check($sformatf("v%0d_idle", k), int'(busy), 0);
        end

        // start during CALC of (12,8) is ignored
        @(negedge clk);
        a_in  = 4'd12;
        b_in  = 4'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in = 4'd3;
        b_in = 4'd5;
        check("ign_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 3; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ign_latency", lat, 4);
        check("ign_result", int'(result), 4);
        check_iters("ign_iters", 2);
        repeat (5) @(posedge clk);
        #1;
        check("ign_hold_result", int'(result), 4);
        check("ign_hold_busy", int'(busy), 0);

        // start held high: a new operation begins in IDLE right after DONE
        @(negedge clk);
        a_in   = 4'd7;
        b_in   = 4'd7;
        start  = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        start = 1'b0;
        check("held_start_pulses", pulses, 3);
        check("held_start_result", int'(result), 7);

        // reset mid-CALC aborts asynchronously
        @(negedge clk);
        a_in  = 4'd15;
        b_in  = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy",   int'(busy),      0);
        check("rst_done",   int'(done),      0);
        check("rst_result", int'(result),    0);
        check("rst_state",  int'(state_dbg), 0);
        check_iters("rst_iter", 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        run_op(4'd6, 4'd9, lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_result", int'(result), 3);
        check_iters("post_rst_iters", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
